// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
// Enable RR_ARBITER_TIMEOUT_EN to build the grant hold-limit logic.
package rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  // Bit k of the result is v[(k + s) mod 8].
  function automatic logic [N_REQ-1:0] rotr(
    input logic [N_REQ-1:0] v,
    input logic [ID_W-1:0]  s
  );
    logic [N_REQ-1:0] r;
    for (int k = 0; k < N_REQ; k++) begin
      r[k] = v[ID_W'(k) + s];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter_prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set bit wins.
// Used as the selection core of the round-robin arbiter.
module prio_enc8
  import rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |in;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (in[k]) idx = ID_W'(k);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant.
// Define RR_ARBITER_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_d;
  logic [ID_W-1:0]  id_d;
  logic             valid_d;
  logic [ID_W-1:0]  enc_idx;
  logic             enc_any;
  logic [ID_W-1:0]  win;

  // Rotate so that the pointer position is encoder bit 0.
  prio_enc8 u_enc (
    .in  (rotr(req, ptr_q)),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign win = enc_idx + ptr_q;

`ifdef RR_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    valid_d = gnt_valid;
`ifdef RR_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d = BUSY;
          id_d    = win;
          gnt_d   = N_REQ'(1) << win;
          valid_d = 1'b1;
`ifdef RR_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (!req[gnt_id]) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = gnt_id + ID_W'(1);
        end
`ifdef RR_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = gnt_id + ID_W'(1);
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      gnt_id    <= id_d;
      gnt_valid <= valid_d;
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      timeout <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      timeout <= to_d;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = (MAX_HOLD != 0);
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter against a behavioural reference model.
// Follows RR_ARBITER_TIMEOUT_EN to decide whether grants time out.
module tb_rr_arbiter;

  localparam int HOLD = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: who holds the grant, for how many cycles, and
  // which requester is first in line at the next arbitration.
  int         holder = -1;
  int         first = 0;
  int         held = 0;
  logic [2:0] last_id = '0;

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction

  task automatic model(input logic [7:0] r, input logic rn, output exp_t e);
    int w;
    e.to = 1'b0;
    if (!rn) begin
      holder = -1; first = 0; held = 0; last_id = '0;
    end else if (holder < 0) begin
      for (int i = 0; i < 8; i++) begin
        w = (first + i) % 8;
        if (r[w]) begin
          holder = w; last_id = 3'(w); held = 1;
          break;
        end
      end
    end else if (!r[holder]) begin
      first = (holder + 1) % 8; holder = -1;
    end else if (TO_EN && held == HOLD) begin
      first = (holder + 1) % 8; holder = -1; e.to = 1'b1;
    end else begin
      held++;
    end
    e.gnt   = (holder >= 0) ? (8'd1 << holder) : 8'd0;
    e.valid = (holder >= 0);
    e.id    = last_id;
  endtask

  task automatic step(input logic [7:0] r, input logic rn);
    exp_t e;
    @(negedge clk);
    req = r;
    rst_n = rn;
    model(r, rn, e);
    q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one expectation per clock edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("gnt_valid", gnt_valid, e.valid);
        chk("timeout", timeout, e.to);
        if (e.valid || !rst_n) chk("gnt_id", gnt_id, e.id);
      end
    end
  end

  initial begin
    logic [7:0] r;
    // reset with every requester active
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);
    // single requester, held then released
    for (int i = 0; i < 6; i++) begin
      step(8'h04, 1'b1);
      if (i == 0) begin
        #1;
        chk("single_gnt", gnt, 8'h04);
      end
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    // fairness: 7 beats 0 after 2 was served, then wrap to 0
    step(8'h81, 1'b1);
    #1;
    chk("fair_first", gnt_id, 7);
    step(8'h81, 1'b1);
    step(8'h01, 1'b1);
    step(8'h81, 1'b1);
    #1;
    chk("fair_wrap", gnt_id, 0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    // full contention from a fresh pointer
    step(8'h00, 1'b0);
    for (int c = 0; c < 40; c++) begin
      r = 8'hFF;
      if (holder >= 0 && held >= 3) r[holder] = 1'b0;
      step(r, 1'b1);
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    // reset while requester 5 holds the grant
    step(8'h20, 1'b1);
    step(8'h20, 1'b1);
    #1;
    chk("pre_reset_gnt", gnt, 8'h20);
    step(8'hFF, 1'b0);
    #1;
    chk("reset_mid_gnt", gnt, 0);
    step(8'hFF, 1'b1);
    #1;
    chk("post_reset_id", gnt_id, 0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    // long hold on 5 with 3 waiting
    step(8'h20, 1'b1);
    for (int c = 0; c < 24; c++) step(8'h28, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    // randomized traffic with sticky holders and rare resets
    for (int c = 0; c < 400; c++) begin
      r = 8'($urandom);
      if (holder >= 0 && $urandom_range(0, 3) != 0) r[holder] = 1'b1;
      step(r, ($urandom_range(0, 49) != 0));
    end
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
